uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte interface between NUM_REQ independent requesters.
- Arbitration is round-robin, with packet lock: a grant is held from the first byte until the byte flagged last has been transmitted.
- Sequences each byte to the transmitter: latch, start pulse, wait for busy to rise, wait for busy to fall.
- Sits between client logic (command responders, debug streamers) and the transmitter inside the UART controller.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_WIDTH, 8, bits per UART character.
- MAX_BURST, 16, bytes per grant before forced rotation; used only when UART_ARB_BURST_LIMIT_EN is defined.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester byte available.
- req_data  input  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  byte is the final byte of the requester's packet.
- req_ready  output  NUM_REQ  one-hot accept pulse; a byte transfers when valid and ready are both high.
- tx_data  output  DATA_WIDTH  byte presented to the transmitter; registered.
- tx_start  output  1  one-cycle start pulse to the transmitter.
- tx_busy  input  1  transmitter busy; rises the cycle after tx_start and falls when the stop bit completes.
- grant_id  output  clog2(NUM_REQ)  current owner; valid while grant_active is high.
- grant_active  output  1  a requester holds the transmitter.

Behaviour:
- Reset values: req_ready=0, tx_data=0, tx_start=0, grant_id=0, grant_active=0, state=IDLE, rr_ptr=NUM_REQ-1 (so requester 0 wins first), latched last flag=0.
- rst asserted in any state, including mid-byte, returns every output to its reset value on the next edge. The transmitter is not aborted; the arbiter re-enters IDLE and waits for tx_busy=0 before granting again.
- IDLE:
  - Condition: any req_valid is high and tx_busy=0.
  - Winner is the first asserted index searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - Next cycle: grant_id=winner, grant_active=1, state → SEND.
  - Decision to grant_active takes exactly 1 cycle.
- SEND:
  - req_ready[grant_id] = req_valid[grant_id] & ~tx_busy. This is combinational; all other ready bits are 0.
  - On handshake: tx_data ← req_data slice, last flag ← req_last[grant_id], state → START.
  - If valid is low, stay in SEND with the grant held (packet lock). Other requesters stay blocked.
- START: tx_start=1 for exactly one cycle; state → WAIT_ACK.
- WAIT_ACK: stay until tx_busy=1, then → WAIT_DONE.
- WAIT_DONE:
  - Stay until tx_busy=0.
  - If last flag=1: rr_ptr ← grant_id, grant_active ← 0, state → IDLE.
  - Otherwise: state → SEND.
- Throughput: handshake to tx_start is 1 cycle. At most one byte is in flight, and req_ready never pulses while tx_busy=1.
- Simultaneous requests in IDLE are resolved by round-robin only; no fixed priority.
- A single-byte packet (valid with last on the first byte) releases the grant after that byte.
- req_data and req_last are sampled only at the handshake; changes outside the handshake are ignored.
- rr_ptr wrap-around: NUM_REQ-1 → 0.
- Invalid state encodings go to IDLE.

Optional Feature:
- Macro: UART_ARB_BURST_LIMIT_EN.
- Defined:
  - A byte counter (clog2(MAX_BURST+1) bits) clears on each grant and increments on each handshake.
  - In WAIT_DONE, count==MAX_BURST is treated as last=1: the grant is released and rr_ptr advances, even mid-packet.
  - The requester re-arbitrates for the remainder of its packet.
- Undefined:
  - No counter is instantiated.
  - The grant is released only on req_last.

Test Plan:
- After reset, req_valid=4'b1111, all single-byte packets with data 0xA0..0xA3, tx_busy model of 10 cycles → tx_data order 0xA0, 0xA1, 0xA2, 0xA3; exactly 4 tx_start pulses; grant_active low between packets.
- Requester 2 sends 3-byte packet 0x11, 0x22, 0x33 (last on 0x33) while requester 0 is valid throughout → all three bytes from req 2 are sent before any byte from req 0; req_ready[0] stays 0 during the packet.
- Requester 1 holds grant and drops valid for 50 cycles mid-packet → no tx_start, grant_id stays 1, and requester 3 remains blocked until req 1 delivers its last byte.
- rst pulsed during WAIT_DONE of byte 0x55 → next edge: tx_start=0, req_ready=0, grant_active=0; after tx_busy falls, arbitration restarts with requester 0 winning.
- tx_busy held high at the IDLE check → no grant until tx_busy=0; req_ready never asserts while tx_busy=1.
- UART_ARB_BURST_LIMIT_EN defined, MAX_BURST=2, req 0 sends a 5-byte packet while req 1 is valid → byte order r0, r0, r1, r0, r0, r0 (req 1's byte is single-byte, last=1).

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter byte port among NUM_REQ requesters.
// Optional: define UART_ARB_BURST_LIMIT_EN to force grant rotation after MAX_BURST bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_start,
  input  logic                          tx_busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          grant_active,
  output logic [2:0]                    state_dbg
);

  // Handshake: a byte moves on a cycle where req_valid[i] and req_ready[i] are both high;
  // ready is only ever offered to the owner, in SEND, while the transmitter is idle.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_START     = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  logic                  last_q;
  logic [ID_W-1:0]       winner;
  logic [ID_W-1:0]       cand;
  logic                  found;
  logic                  hs;
  logic                  rel_grant;
  logic [DATA_WIDTH-1:0] sel_data;

  assign state_dbg = state;
  assign sel_data  = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign hs        = (state == S_SEND) && req_valid[grant_id] && !tx_busy;

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_SEND && !tx_busy) req_ready[grant_id] = req_valid[grant_id];
  end

`ifdef UART_ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] burst_cnt;
  assign rel_grant = last_q || (burst_cnt == CNT_W'(MAX_BURST));
`else
  assign rel_grant = last_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      tx_data      <= '0;
      tx_start     <= 1'b0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      rr_ptr       <= ID_W'(NUM_REQ - 1);
      last_q       <= 1'b0;
`ifdef UART_ARB_BURST_LIMIT_EN
      burst_cnt    <= '0;
`endif
    end else begin
      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found && !tx_busy) begin
            grant_id     <= winner;
            grant_active <= 1'b1;
            state        <= S_SEND;
`ifdef UART_ARB_BURST_LIMIT_EN
            burst_cnt    <= '0;
`endif
          end
        end
        S_SEND: begin
          if (hs) begin
            tx_data  <= sel_data;
            last_q   <= req_last[grant_id];
            tx_start <= 1'b1;
            state    <= S_START;
`ifdef UART_ARB_BURST_LIMIT_EN
            burst_cnt <= burst_cnt + 1'b1;
`endif
          end
        end
        S_START: state <= S_WAIT_ACK;
        S_WAIT_ACK: begin
          if (tx_busy) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            if (rel_grant) begin
              rr_ptr       <= grant_id;
              grant_active <= 1'b0;
              state        <= S_IDLE;
            end else begin
              state <= S_SEND;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requester drivers, a 10-cycle transmitter model and an expected-byte scoreboard.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
`ifdef UART_ARB_BURST_LIMIT_EN
  localparam int MB = 2;
`else
  localparam int MB = 16;
`endif
  localparam int SB_W = 2 + DW;

  logic               clk;
  logic               rst;
  logic [NR-1:0]      req_valid;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_last;
  logic [NR-1:0]      req_ready;
  logic [DW-1:0]      tx_data;
  logic               tx_start;
  logic               tx_busy;
  logic [1:0]         grant_id;
  logic               grant_active;
  logic [2:0]         state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;
  int start_cnt    = 0;
  int gfall        = 0;
  int busy_cnt     = 0;
  logic busy_force;
  logic [NR-1:0] hold;

  logic [8:0]      src_q[NR][$];
  logic [SB_W-1:0] exp_q[$];

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant_id(grant_id), .grant_active(grant_active), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // requester drivers: present queue heads at the falling edge
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (src_q[i].size() > 0 && !hold[i]) begin
          req_valid[i]         = 1'b1;
          req_data[i*DW +: DW] = src_q[i][0][7:0];
          req_last[i]          = src_q[i][0][8];
        end else begin
          req_valid[i]         = 1'b0;
          req_data[i*DW +: DW] = '0;
          req_last[i]          = 1'b0;
        end
      end
    end
  end

  // transmitter model, handshake pops and scoreboard
  initial begin
    logic [NR-1:0]   hsv;
    logic            st;
    logic [SB_W-1:0] got;
    logic [SB_W-1:0] e;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      hsv = req_valid & req_ready;
      st  = tx_start;
      got = {grant_id, tx_data};
      #1;
      for (int i = 0; i < NR; i++)
        if (hsv[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (st) begin
        start_cnt++;
        busy_cnt = 10;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL sb_unexpected: got id/data %h, required none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            tests_failed++;
            $display("[TB] FAIL sb_byte: got id/data %h, required %h", got, e);
          end
        end
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      tx_busy = (busy_cnt > 0) || busy_force;
    end
  end

  // handshake invariants checked every cycle
  initial begin
    logic ga_prev;
    ga_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        tests_run++;
        if ((|(req_ready & ~req_valid)) || (tx_busy && |req_ready) || !$onehot0(req_ready)) begin
          tests_failed++;
          $display("[TB] FAIL ready_rule: got ready=%b valid=%b busy=%b, required one-hot, valid-qualified, idle-only",
                   req_ready, req_valid, tx_busy);
        end
      end
      if (ga_prev && !grant_active) gfall++;
      ga_prev = grant_active;
    end
  end

  function automatic bit drained();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e && exp_q.size() == 0 && !grant_active && !tx_busy;
  endfunction

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!drained() && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (!drained()) begin
      tests_failed++;
      $display("[TB] FAIL %s_drain: got %0d bytes still expected after %0d cycles, required 0", name, exp_q.size(), n);
      exp_q.delete();
      for (int i = 0; i < NR; i++) src_q[i].delete();
    end
  endtask

  task automatic push(input int id, input logic [7:0] d, input logic last);
    src_q[id].push_back({last, d});
    exp_q.push_back({id[1:0], d});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({req_ready, tx_data, tx_start, grant_id, grant_active, state_dbg} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got ready=%b data=%h start=%b id=%0d active=%b state=%0d, required all 0",
               req_ready, tx_data, tx_start, grant_id, grant_active, state_dbg);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int s0, g0;
    s0 = start_cnt;
    g0 = gfall;
    for (int i = 0; i < NR; i++) push(i, 8'hA0 + 8'(i), 1'b1);
    wait_drain("round_robin");
    tests_run++;
    if (start_cnt - s0 != 4) begin
      tests_failed++;
      $display("[TB] FAIL rr_starts: got %0d tx_start pulses, required 4", start_cnt - s0);
    end
    tests_run++;
    if (gfall - g0 != 4) begin
      tests_failed++;
      $display("[TB] FAIL rr_release: got %0d grant releases, required 4", gfall - g0);
    end
  endtask

  task automatic test_packet_lock();
    int n, viol;
    push(2, 8'h11, 1'b0);
    push(2, 8'h22, 1'b0);
    push(2, 8'h33, 1'b1);
    n = 0;
    while (!(grant_active && grant_id == 2'd2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (!(grant_active && grant_id == 2'd2)) begin
      tests_failed++;
      $display("[TB] FAIL lock_grant: got active=%b id=%0d, required active=1 id=2", grant_active, grant_id);
    end
    push(0, 8'h44, 1'b1);
    viol = 0;
    n = 0;
    while (!drained() && n < 500) begin
      @(negedge clk);
      n++;
      if (grant_active && grant_id == 2'd2 && req_ready[0]) viol++;
    end
    tests_run++;
    if (viol != 0) begin
      tests_failed++;
      $display("[TB] FAIL lock_ready0: got %0d cycles of req_ready[0] during req 2 packet, required 0", viol);
    end
    wait_drain("packet_lock");
  endtask

  task automatic test_valid_gap();
    int n, s0, viol;
    push(1, 8'h61, 1'b0);
    push(1, 8'h62, 1'b1);
    push(3, 8'h73, 1'b1);
    n = 0;
    while (src_q[1].size() != 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    hold[1] = 1'b1;
    repeat (15) @(negedge clk);
    s0 = start_cnt;
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (!(grant_active && grant_id == 2'd1) || req_ready[3]) viol++;
    end
    tests_run++;
    if (viol != 0) begin
      tests_failed++;
      $display("[TB] FAIL gap_hold: got %0d cycles without grant to req 1 or with req 3 ready, required 0", viol);
    end
    tests_run++;
    if (start_cnt != s0) begin
      tests_failed++;
      $display("[TB] FAIL gap_starts: got %0d tx_start pulses during gap, required 0", start_cnt - s0);
    end
    hold[1] = 1'b0;
    wait_drain("valid_gap");
  endtask

  task automatic test_reset_mid_byte();
    int n, viol;
    push(2, 8'h55, 1'b1);
    n = 0;
    while (state_dbg != 3'd4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (tx_start !== 1'b0 || req_ready !== '0 || grant_active !== 1'b0 || grant_id !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: got start=%b ready=%b active=%b id=%0d, required 0 0 0 0",
               tx_start, req_ready, grant_active, grant_id);
    end
    tests_run++;
    if (tx_busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_busy: got tx_busy=%b at reset, required 1 (byte still on the line)", tx_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    push(0, 8'h50, 1'b1);
    push(1, 8'h5A, 1'b1);
    viol = 0;
    n = 0;
    while (tx_busy && n < 50) begin
      @(negedge clk);
      n++;
      if (tx_busy && grant_active) viol++;
    end
    tests_run++;
    if (viol != 0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_wait: got %0d granted cycles while busy, required 0", viol);
    end
    wait_drain("reset_mid_byte");
  endtask

  task automatic test_busy_hold();
    int viol;
    busy_force = 1'b1;
    @(negedge clk);
    push(3, 8'h3C, 1'b1);
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (grant_active || req_ready != '0) viol++;
    end
    tests_run++;
    if (viol != 0) begin
      tests_failed++;
      $display("[TB] FAIL busy_block: got %0d cycles granted or ready while busy, required 0", viol);
    end
    busy_force = 1'b0;
    wait_drain("busy_hold");
  endtask

  task automatic test_burst();
    src_q[0].push_back({1'b0, 8'hB0});
    src_q[0].push_back({1'b0, 8'hB1});
    src_q[0].push_back({1'b0, 8'hB2});
    src_q[0].push_back({1'b0, 8'hB3});
    src_q[0].push_back({1'b1, 8'hB4});
    src_q[1].push_back({1'b1, 8'hC1});
`ifdef UART_ARB_BURST_LIMIT_EN
    exp_q.push_back({2'd0, 8'hB0});
    exp_q.push_back({2'd0, 8'hB1});
    exp_q.push_back({2'd1, 8'hC1});
    exp_q.push_back({2'd0, 8'hB2});
    exp_q.push_back({2'd0, 8'hB3});
    exp_q.push_back({2'd0, 8'hB4});
`else
    exp_q.push_back({2'd0, 8'hB0});
    exp_q.push_back({2'd0, 8'hB1});
    exp_q.push_back({2'd0, 8'hB2});
    exp_q.push_back({2'd0, 8'hB3});
    exp_q.push_back({2'd0, 8'hB4});
    exp_q.push_back({2'd1, 8'hC1});
`endif
    wait_drain("burst");
  endtask

  initial begin
    rst        = 1'b1;
    hold       = '0;
    busy_force = 1'b0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_valid_gap();
    test_reset_mid_byte();
    test_busy_hold();
    test_burst();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL final_queue: got %0d leftover expected bytes, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
